score_tally: RTL and testbench
==============================

// Module: score_tally
// PURPOSE
//  Downstream of scoreKeeper: consumes its add1/add2/sub2 point strobes and keeps two per-player scores.
//  Drives one active-low seven-segment digit per player on the DE1 HEX displays.
//  Detects the first player to reach WIN_SCORE, flags the winner and freezes the scoreboard until reset.
// PARAMETERS
//  WIN_SCORE  7           winning score, legal range 1..9; scores never exceed it
//  BLINK_DIV  25_000_000  clk cycles per blink half-period (used only with SCORE_BLINK_EN)
// PORTS
//  clk        in   1  system clock, all state on posedge
//  Reset      in   1  asynchronous, active-low reset (0 = reset)
//  add1       in   1  player-1 point strobe from scoreKeeper
//  add2       in   1  player-2 point strobe from scoreKeeper
//  sub2       in   1  player-2 penalty strobe from scoreKeeper
//  HEX0       out  7  player-1 digit, active-low segments {g,f,e,d,c,b,a}
//  HEX1       out  7  player-2 digit, same encoding
//  win1       out  1  player 1 has won
//  win2       out  1  player 2 has won
//  game_over  out  1  win1 | win2
// BEHAVIOUR
//  - Reset=0 (async): score1=0, score2=0, state=PLAY, edge registers=0, blink counter=0, blink phase=on.
//    While in reset: HEX0=HEX1=7'b1000000 ("0"), win1=win2=game_over=0. Reset may assert in any state, mid-game.
//  - Edge detect: each input is registered every cycle (prev_x).
//    event_x = x & ~prev_x; a level held high for N cycles counts once.
//  - Latency: the score register updates on the posedge where x is first sampled high.
//    HEX/win outputs follow combinationally from the registers: 1-cycle latency, strobe to display.
//  - Scores: 4-bit unsigned, range 0..WIN_SCORE.
//    event_add1: score1+1. event_add2: score2+1. event_sub2: score2-1, saturating at 0.
//  - Same edge add2 & sub2: net 0, score2 unchanged.
//  - Same edge add1 & add2: both applied.
//  - FSM PLAY -> P1WIN when next score1 == WIN_SCORE. PLAY -> P2WIN when next score2 == WIN_SCORE.
//    If both reach WIN_SCORE on the same edge, P1WIN wins the tie.
//  - P1WIN and P2WIN are absorbing until Reset; all events are ignored and scores are frozen.
//  - win1 = (state==P1WIN), win2 = (state==P2WIN); they are never both 1.
//  - Seven-seg decode, active-low:
//    0=1000000  1=1111001  2=0100100  3=0110000  4=0011001
//    5=0010010  6=0000010  7=1111000  8=0000000  9=0010000
//    Any value >9 shows 7'b1111111 (unreachable).
// CONFIGURATION
//  SCORE_BLINK_EN defined:
//    - In P1WIN/P2WIN a counter counts 0..BLINK_DIV-1; the phase toggles when it wraps.
//    - The winner's digit shows 7'b1111111 (blank) during the off phase. The loser's digit stays steady.
//    - In PLAY the counter is held at 0 and the phase at on.
//  SCORE_BLINK_EN undefined:
//    - No counter logic is built and BLINK_DIV is unused. The winner's digit is steady.
// TESTING (bench: WIN_SCORE=3, BLINK_DIV=4)
//  1. Reset=0 for 3 cycles, then release -> HEX0=HEX1=1000000, win1=win2=game_over=0.
//  2. add1 held high 5 cycles -> score1=1 only; HEX0=1111001 one cycle after the rise.
//  3. add2 pulse x2, then sub2 pulse x3 -> HEX1: 1 -> 2 -> 1 -> 0 -> 0 (saturates).
//  4. add2 & sub2 rise on the same edge -> score2 unchanged.
//     Then add1 & add2 rise together from 2/2 -> both reach 3, win1=1, win2=0.
//  5. In P1WIN, pulse add2/sub2/add1 -> no change.
//     With SCORE_BLINK_EN, HEX0 alternates 0110000/1111111 every 4 cycles and HEX1 is steady.
//  6. Assert Reset=0 mid-game (score 2/1), asynchronously between edges -> outputs clear immediately.
//     After release, the first add1 edge gives score1=1.

Source files
------------

// File: rtl/score_tally.sv
// rtl/score_tally.sv - two-player score tally with seven-segment digits and winner freeze
// Optional feature: define SCORE_BLINK_EN to blink the winner's digit.
module score_tally #(
    parameter int WIN_SCORE = 7,
    parameter int BLINK_DIV = 25_000_000
) (
    input  logic       clk,
    input  logic       Reset,
    input  logic       add1,
    input  logic       add2,
    input  logic       sub2,
    output logic [6:0] HEX0,
    output logic [6:0] HEX1,
    output logic       win1,
    output logic       win2,
    output logic       game_over
);

    typedef enum logic [1:0] {
        PLAY  = 2'd0,
        P1WIN = 2'd1,
        P2WIN = 2'd2
    } state_t;

    localparam logic [3:0] WIN_VAL = 4'(WIN_SCORE);
    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    state_t     state_q, state_d;
    logic [3:0] score1_q, score1_d;
    logic [3:0] score2_q, score2_d;
    logic       prev_add1_q, prev_add2_q, prev_sub2_q;
    logic       event_add1, event_add2, event_sub2;
    logic       blank1, blank2;

    function automatic logic [6:0] seg7(input logic [3:0] v);
        case (v)
            4'd0:    seg7 = 7'b1000000;
            4'd1:    seg7 = 7'b1111001;
            4'd2:    seg7 = 7'b0100100;
            4'd3:    seg7 = 7'b0110000;
            4'd4:    seg7 = 7'b0011001;
            4'd5:    seg7 = 7'b0010010;
            4'd6:    seg7 = 7'b0000010;
            4'd7:    seg7 = 7'b1111000;
            4'd8:    seg7 = 7'b0000000;
            4'd9:    seg7 = 7'b0010000;
            default: seg7 = SEG_BLANK;
        endcase
    endfunction

    assign event_add1 = add1 & ~prev_add1_q;
    assign event_add2 = add2 & ~prev_add2_q;
    assign event_sub2 = sub2 & ~prev_sub2_q;

    always_ff @(posedge clk or negedge Reset) begin
        if (!Reset) begin
            prev_add1_q <= 1'b0;
            prev_add2_q <= 1'b0;
            prev_sub2_q <= 1'b0;
        end else begin
            prev_add1_q <= add1;
            prev_add2_q <= add2;
            prev_sub2_q <= sub2;
        end
    end

    always_ff @(posedge clk or negedge Reset) begin
        if (!Reset) begin
            state_q  <= PLAY;
            score1_q <= 4'd0;
            score2_q <= 4'd0;
        end else begin
            state_q  <= state_d;
            score1_q <= score1_d;
            score2_q <= score2_d;
        end
    end

    // Scores only move in PLAY; once a winner exists everything is frozen.
    always_comb begin
        state_d  = state_q;
        score1_d = score1_q;
        score2_d = score2_q;
        if (state_q == PLAY) begin
            if (event_add1 && score1_q != WIN_VAL) begin
                score1_d = score1_q + 4'd1;
            end
            if (event_add2 && !event_sub2) begin
                if (score2_q != WIN_VAL) begin
                    score2_d = score2_q + 4'd1;
                end
            end else if (event_sub2 && !event_add2) begin
                if (score2_q != 4'd0) begin
                    score2_d = score2_q - 4'd1;
                end
            end
            if (score1_d == WIN_VAL) begin
                state_d = P1WIN;
            end else if (score2_d == WIN_VAL) begin
                state_d = P2WIN;
            end
        end
    end

`ifdef SCORE_BLINK_EN
    localparam int CNT_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(BLINK_DIV - 1);

    logic [CNT_W-1:0] blink_cnt_q, blink_cnt_d;
    logic             blink_on_q, blink_on_d;

    always_ff @(posedge clk or negedge Reset) begin
        if (!Reset) begin
            blink_cnt_q <= '0;
            blink_on_q  <= 1'b1;
        end else begin
            blink_cnt_q <= blink_cnt_d;
            blink_on_q  <= blink_on_d;
        end
    end

    always_comb begin
        blink_cnt_d = '0;
        blink_on_d  = 1'b1;
        if (state_q != PLAY) begin
            blink_on_d = blink_on_q;
            if (blink_cnt_q == CNT_MAX) begin
                blink_cnt_d = '0;
                blink_on_d  = ~blink_on_q;
            end else begin
                blink_cnt_d = blink_cnt_q + 1'b1;
            end
        end
    end

    assign blank1 = (state_q == P1WIN) && !blink_on_q;
    assign blank2 = (state_q == P2WIN) && !blink_on_q;
`else
    assign blank1 = 1'b0;
    assign blank2 = 1'b0;
`endif

    assign HEX0      = blank1 ? SEG_BLANK : seg7(score1_q);
    assign HEX1      = blank2 ? SEG_BLANK : seg7(score2_q);
    assign win1      = (state_q == P1WIN);
    assign win2      = (state_q == P2WIN);
    assign game_over = win1 | win2;

endmodule

// File: tb/tb_score_tally.sv
// tb/tb_score_tally.sv - self-checking bench for score_tally (WIN_SCORE=3, BLINK_DIV=4)
module tb_score_tally;

    localparam int WS = 3;
    localparam int BD = 4;
`ifdef SCORE_BLINK_EN
    localparam bit BLINK = 1'b1;
`else
    localparam bit BLINK = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       Reset = 1'b0;
    logic       add1 = 1'b0, add2 = 1'b0, sub2 = 1'b0;
    logic [6:0] HEX0, HEX1;
    logic       win1, win2, game_over;

    int checks = 0;
    int errors = 0;

    // Reference model state: plain integers, winner index 0 = none.
    int m_s1, m_s2, m_win, m_age;
    bit m_p1, m_p2, m_p3;

    logic [6:0] seg_tab [0:9];

    score_tally #(.WIN_SCORE(WS), .BLINK_DIV(BD)) dut (
        .clk(clk), .Reset(Reset), .add1(add1), .add2(add2), .sub2(sub2),
        .HEX0(HEX0), .HEX1(HEX1), .win1(win1), .win2(win2), .game_over(game_over)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit         a1, a2, s2;
        logic [6:0] h0, h1;
        bit         w1, w2;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string name, input logic [6:0] got, input logic [6:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b at %0t", name, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_s1 = 0; m_s2 = 0; m_win = 0; m_age = 0;
        m_p1 = 0; m_p2 = 0; m_p3 = 0;
    endtask

    task automatic model_edge(input bit a1, input bit a2, input bit s2);
        bit e1, e2, e3;
        e1 = a1 && !m_p1;
        e2 = a2 && !m_p2;
        e3 = s2 && !m_p3;
        if (m_win == 0) begin
            if (e1) m_s1++;
            if (e2 && !e3) m_s2++;
            else if (e3 && !e2 && m_s2 > 0) m_s2--;
            if (m_s1 == WS) begin m_win = 1; m_age = 0; end
            else if (m_s2 == WS) begin m_win = 2; m_age = 0; end
        end else begin
            m_age++;
        end
        m_p1 = a1; m_p2 = a2; m_p3 = s2;
    endtask

    function automatic logic [6:0] shown(input int player, input logic [6:0] steady);
        if (BLINK && m_win == player && ((m_age / BD) % 2 == 1)) return 7'b1111111;
        return steady;
    endfunction

    task automatic check_model(input string tag);
        chk({tag, ".hex0"}, HEX0, shown(1, seg_tab[m_s1]));
        chk({tag, ".hex1"}, HEX1, shown(2, seg_tab[m_s2]));
        chk({tag, ".win1"}, {6'd0, win1}, {6'd0, m_win == 1});
        chk({tag, ".win2"}, {6'd0, win2}, {6'd0, m_win == 2});
        chk({tag, ".game_over"}, {6'd0, game_over}, {6'd0, m_win != 0});
    endtask

    task automatic step(input bit a1, input bit a2, input bit s2);
        @(negedge clk);
        add1 = a1; add2 = a2; sub2 = s2;
        @(posedge clk);
        model_edge(a1, a2, s2);
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        Reset = 0; add1 = 0; add2 = 0; sub2 = 0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        @(negedge clk);
        Reset = 1;
    endtask

    function automatic vec_t mk(input bit a1, a2, s2, input logic [6:0] h0, h1, input bit w1, w2);
        vec_t v;
        v.a1 = a1; v.a2 = a2; v.s2 = s2; v.h0 = h0; v.h1 = h1; v.w1 = w1; v.w2 = w2;
        return v;
    endfunction

    localparam logic [6:0] D0 = 7'b1000000, D1 = 7'b1111001, D2 = 7'b0100100, D3 = 7'b0110000;

    initial begin
        seg_tab[0] = 7'b1000000; seg_tab[1] = 7'b1111001; seg_tab[2] = 7'b0100100;
        seg_tab[3] = 7'b0110000; seg_tab[4] = 7'b0011001; seg_tab[5] = 7'b0010010;
        seg_tab[6] = 7'b0000010; seg_tab[7] = 7'b1111000; seg_tab[8] = 7'b0000000;
        seg_tab[9] = 7'b0010000;

        // add1 held for 5 cycles counts once
        repeat (5) vecs.push_back(mk(1, 0, 0, D1, D0, 0, 0));
        vecs.push_back(mk(0, 0, 0, D1, D0, 0, 0));
        // add2 x2 then sub2 x3 with saturation
        vecs.push_back(mk(0, 1, 0, D1, D1, 0, 0));
        vecs.push_back(mk(0, 0, 0, D1, D1, 0, 0));
        vecs.push_back(mk(0, 1, 0, D1, D2, 0, 0));
        vecs.push_back(mk(0, 0, 0, D1, D2, 0, 0));
        vecs.push_back(mk(0, 0, 1, D1, D1, 0, 0));
        vecs.push_back(mk(0, 0, 0, D1, D1, 0, 0));
        vecs.push_back(mk(0, 0, 1, D1, D0, 0, 0));
        vecs.push_back(mk(0, 0, 0, D1, D0, 0, 0));
        vecs.push_back(mk(0, 0, 1, D1, D0, 0, 0));
        vecs.push_back(mk(0, 0, 0, D1, D0, 0, 0));
        // add2 & sub2 together, then climb to 2/2
        vecs.push_back(mk(0, 1, 1, D1, D0, 0, 0));
        vecs.push_back(mk(0, 0, 0, D1, D0, 0, 0));
        vecs.push_back(mk(1, 0, 0, D2, D0, 0, 0));
        vecs.push_back(mk(0, 0, 0, D2, D0, 0, 0));
        vecs.push_back(mk(0, 1, 0, D2, D1, 0, 0));
        vecs.push_back(mk(0, 0, 0, D2, D1, 0, 0));
        vecs.push_back(mk(0, 1, 0, D2, D2, 0, 0));
        vecs.push_back(mk(0, 0, 0, D2, D2, 0, 0));
        // simultaneous win: player 1 takes the tie
        vecs.push_back(mk(1, 1, 0, D3, D3, 1, 0));
        vecs.push_back(mk(0, 0, 0, D3, D3, 1, 0));
        // frozen in P1WIN
        vecs.push_back(mk(0, 1, 0, D3, D3, 1, 0));
        vecs.push_back(mk(0, 0, 0, D3, D3, 1, 0));
        vecs.push_back(mk(0, 0, 1, D3, D3, 1, 0));
        vecs.push_back(mk(0, 0, 0, D3, D3, 1, 0));
        vecs.push_back(mk(1, 0, 0, D3, D3, 1, 0));
        repeat (6) vecs.push_back(mk(0, 0, 0, D3, D3, 1, 0));

        // reset state
        do_reset();
        #1;
        chk("reset.hex0", HEX0, D0);
        chk("reset.hex1", HEX1, D0);
        chk("reset.flags", {4'd0, win1, win2, game_over}, 7'd0);

        foreach (vecs[i]) begin
            step(vecs[i].a1, vecs[i].a2, vecs[i].s2);
            chk($sformatf("vec%0d.hex0", i), HEX0, shown(1, vecs[i].h0));
            chk($sformatf("vec%0d.hex1", i), HEX1, vecs[i].h1);
            chk($sformatf("vec%0d.win1", i), {6'd0, win1}, {6'd0, vecs[i].w1});
            chk($sformatf("vec%0d.win2", i), {6'd0, win2}, {6'd0, vecs[i].w2});
            chk($sformatf("vec%0d.go", i), {6'd0, game_over}, {6'd0, vecs[i].w1 | vecs[i].w2});
        end

        // asynchronous reset mid-game at score 2/1
        do_reset();
        step(1, 0, 0); step(0, 0, 0); step(1, 0, 0); step(0, 0, 0); step(0, 1, 0); step(0, 0, 0);
        chk("pre_async.hex0", HEX0, D2);
        chk("pre_async.hex1", HEX1, D1);
        @(posedge clk);
        #3;
        Reset = 0;
        model_reset();
        #1;
        chk("async.hex0", HEX0, D0);
        chk("async.hex1", HEX1, D0);
        chk("async.flags", {4'd0, win1, win2, game_over}, 7'd0);
        @(negedge clk);
        Reset = 1;
        step(1, 0, 0);
        chk("after_async.hex0", HEX0, D1);
        chk("after_async.hex1", HEX1, D0);

        // randomized games against the reference model
        for (int g = 0; g < 12; g++) begin
            do_reset();
            for (int c = 0; c < 60; c++) begin
                step($urandom_range(0, 2) == 0, $urandom_range(0, 2) == 0, $urandom_range(0, 3) == 0);
                check_model($sformatf("rnd%0d_%0d", g, c));
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
